// File: rtl/reflet_irq_scheduler.sv
// Reflet interrupt scheduler: edge-latched pending, enable mask, fixed priority, CPU req/ack/done.
// Optional preemptive nesting is compiled in with `define REFLET_IRQ_NESTING_EN.
module reflet_irq_scheduler #(
  parameter int NUM_SRC = 4,
  parameter int WORD    = 16,
  parameter int ID_W    = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_addr,
  input  logic [WORD-1:0]    cfg_wdata,
  output logic [WORD-1:0]    cfg_rdata,
  output logic               int_req,
  output logic [ID_W-1:0]    int_num,
  input  logic               int_ack,
  input  logic               int_done
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  localparam int RW = (WORD > 10) ? WORD : 10;

  state_t             state, state_nx;
  logic [NUM_SRC-1:0] prev;
  logic [NUM_SRC-1:0] pending, pending_nx;
  logic [NUM_SRC-1:0] enable;
  logic               gen;
  logic [NUM_SRC-1:0] active, active_nx;

  logic [NUM_SRC-1:0] edges, cand, win_oh, act_low, clr_mask;
  logic [ID_W-1:0]    win_idx;
  logic               win_any, qualify;
  logic [RW-1:0]      rd;
  logic               unused_wdata;

  function automatic logic [NUM_SRC-1:0] lowbit(input logic [NUM_SRC-1:0] v);
    return v & (~v + NUM_SRC'(1));
  endfunction

  assign edges    = irq_in & ~prev;
  assign cand     = pending & enable & {NUM_SRC{gen}};
  assign win_oh   = lowbit(cand);
  assign win_any  = |cand;
  assign act_low  = lowbit(active);
  // A winner may only be requested if it outranks everything already in service.
  assign qualify  = win_any && ((active == '0) || (win_oh < act_low));
  assign clr_mask = (cfg_we && cfg_addr == 2'd1) ? cfg_wdata[NUM_SRC-1:0] : '0;
  assign unused_wdata = &{1'b0, cfg_wdata};

  always_comb begin
    win_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (cand[i]) win_idx = ID_W'(i);
    end
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    state_nx   = state;
    pending_nx = pending & ~clr_mask;
    active_nx  = active;
    case (state)
      S_IDLE: begin
        if (win_any) state_nx = S_REQ;
      end
      S_REQ: begin
        if (int_ack && qualify) begin
          pending_nx = pending_nx & ~win_oh;
          active_nx  = active | win_oh;
          state_nx   = S_SERVICE;
        end else if (!qualify) begin
          state_nx = (active == '0) ? S_IDLE : S_SERVICE;
        end
`ifdef REFLET_IRQ_NESTING_EN
        // Ack is applied first, so a simultaneous done retires the source just acked.
        if (int_done && active_nx != '0) begin
          active_nx = active_nx & ~lowbit(active_nx);
          if (active_nx == '0 && state_nx == S_SERVICE) state_nx = S_IDLE;
        end
`endif
      end
      S_SERVICE: begin
        if (int_done && active != '0) begin
          active_nx = active & ~act_low;
          if (active_nx == '0) state_nx = S_IDLE;
        end
`ifdef REFLET_IRQ_NESTING_EN
        if (state_nx == S_SERVICE && win_any && (win_oh < lowbit(active_nx)))
          state_nx = S_REQ;
`endif
      end
      default: state_nx = S_IDLE;
    endcase
    // A fresh edge overrides any clear in the same cycle.
    pending_nx = pending_nx | edges;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      prev    <= '0;
      pending <= '0;
      enable  <= '0;
      gen     <= 1'b0;
      active  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state   <= state_nx;
      prev    <= irq_in;
      pending <= pending_nx;
      active  <= active_nx;
      if (cfg_we && cfg_addr == 2'd0) begin
        enable <= cfg_wdata[NUM_SRC-1:0];
        gen    <= cfg_wdata[WORD-1];
      end
    end
  end

  assign int_req = (state == S_REQ);
  assign int_num = (state == S_REQ) ? win_idx : '0;

  always_comb begin
    rd = '0;
    case (cfg_addr)
      2'd0: begin
        rd[NUM_SRC-1:0] = enable;
        rd[WORD-1]      = gen;
      end
      2'd1: rd[NUM_SRC-1:0] = pending;
      2'd2: begin
        rd[NUM_SRC-1:0] = active;
        rd[9:8]         = state;
      end
      default: rd = '0;
    endcase
  end

  assign cfg_rdata = rd[WORD-1:0];

endmodule

// File: tb/tb_reflet_irq_scheduler.sv
// Self-checking bench for reflet_irq_scheduler: vector table plus hand-written multi-cycle sequences.
// Expectations for the preemption case follow REFLET_IRQ_NESTING_EN.
module tb_reflet_irq_scheduler;

  localparam int NUM_SRC = 4;
  localparam int WORD    = 16;
  localparam int ID_W    = 3;

  logic               clk;
  logic               reset;
  logic [NUM_SRC-1:0] irq_in;
  logic               cfg_we;
  logic [1:0]         cfg_addr;
  logic [WORD-1:0]    cfg_wdata;
  logic [WORD-1:0]    cfg_rdata;
  logic               int_req;
  logic [ID_W-1:0]    int_num;
  logic               int_ack;
  logic               int_done;

  reflet_irq_scheduler #(.NUM_SRC(NUM_SRC), .WORD(WORD), .ID_W(ID_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .irq_in    (irq_in),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_rdata (cfg_rdata),
    .int_req   (int_req),
    .int_num   (int_num),
    .int_ack   (int_ack),
    .int_done  (int_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  irq;
    logic        we;
    logic [1:0]  addr;
    logic [15:0] wdata;
    logic        ack;
    logic        done;
    logic [1:0]  raddr;
    logic        exp_req;
    logic [2:0]  exp_num;
    logic [15:0] exp_rd;
  } vec_t;

  typedef struct {
    string       name;
    logic        req;
    logic [2:0]  num;
    logic [1:0]  raddr;
    logic [15:0] rd;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string name, input logic req, input logic [2:0] num,
                          input logic [1:0] raddr, input logic [15:0] rdv);
    exp_t e;
    e.name = name; e.req = req; e.num = num; e.raddr = raddr; e.rd = rdv;
    sb.push_back(e);
  endtask

  task automatic compare_next();
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_empty: got no expectation, want one");
    end else begin
      e = sb.pop_front();
      cfg_addr = e.raddr;
      #1;
      check({e.name, ".int_req"}, 32'(int_req), 32'(e.req));
      if (e.req) check({e.name, ".int_num"}, 32'(int_num), 32'(e.num));
      check({e.name, ".rdata"}, 32'(cfg_rdata), 32'(e.rd));
    end
  endtask

  task automatic expect_out(input string name, input logic req, input logic [2:0] num,
                            input logic [1:0] raddr, input logic [15:0] rdv);
    push_exp(name, req, num, raddr, rdv);
    compare_next();
  endtask

  task automatic do_wr(input logic [1:0] a, input logic [15:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic pulse(input logic [3:0] m);
    irq_in = m;
    tick();
    irq_in = '0;
  endtask

  task automatic do_ack();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  task automatic do_done();
    int_done = 1'b1;
    tick();
    int_done = 1'b0;
  endtask

  localparam int NV = 11;
  vec_t vt[NV];

  initial begin
    //        name        irq   we    addr  wdata     ack   done  raddr req   num   rdata
    vt[0]  = '{"en_lo",   4'h0, 1'b1, 2'd0, 16'h8001, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0, 16'h8001};
    vt[1]  = '{"edge2",   4'h4, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 2'd1, 1'b0, 3'd0, 16'h0004};
    vt[2]  = '{"masked1", 4'h0, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 2'd1, 1'b0, 3'd0, 16'h0004};
    vt[3]  = '{"masked2", 4'h0, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 2'd2, 1'b0, 3'd0, 16'h0000};
    vt[4]  = '{"en_src2", 4'h0, 1'b1, 2'd0, 16'h8004, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0, 16'h8004};
    vt[5]  = '{"req2",    4'h0, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 2'd1, 1'b1, 3'd2, 16'h0004};
    vt[6]  = '{"ack2",    4'h0, 1'b0, 2'd0, 16'h0000, 1'b1, 1'b0, 2'd1, 1'b0, 3'd0, 16'h0000};
    vt[7]  = '{"svc2",    4'h0, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 2'd2, 1'b0, 3'd0, 16'h0204};
    vt[8]  = '{"done2",   4'h0, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b1, 2'd2, 1'b0, 3'd0, 16'h0000};
    vt[9]  = '{"wr_a3",   4'h0, 1'b1, 2'd3, 16'hFFFF, 1'b0, 1'b0, 2'd3, 1'b0, 3'd0, 16'h0000};
    vt[10] = '{"en_keep", 4'h0, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0, 16'h8004};

    reset = 1'b1; irq_in = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    int_ack = 1'b0; int_done = 1'b0;
    #3;
    expect_out("reset_state", 1'b0, 3'd0, 2'd0, 16'h0000);
    #8;
    reset = 1'b0;
    tick();

    // Single request through the vector table
    for (int i = 0; i < NV; i++) begin
      irq_in = vt[i].irq; cfg_we = vt[i].we; cfg_addr = vt[i].addr; cfg_wdata = vt[i].wdata;
      int_ack = vt[i].ack; int_done = vt[i].done;
      push_exp(vt[i].name, vt[i].exp_req, vt[i].exp_num, vt[i].raddr, vt[i].exp_rd);
      tick();
      cfg_we = 1'b0; int_ack = 1'b0; int_done = 1'b0;
      compare_next();
    end
    irq_in = '0;

    // Fixed priority between simultaneous edges
    do_wr(2'd0, 16'h800F);
    pulse(4'b1010);
    tick();
    expect_out("prio_first", 1'b1, 3'd1, 2'd1, 16'h000A);
    do_ack();
    expect_out("prio_ack", 1'b0, 3'd0, 2'd2, 16'h0202);
    do_done();
    expect_out("prio_done", 1'b0, 3'd0, 2'd2, 16'h0000);
    tick();
    expect_out("prio_second", 1'b1, 3'd3, 2'd1, 16'h0008);
    do_ack();
    do_done();

    // Winner re-evaluated while requesting
    pulse(4'b0100);
    tick();
    expect_out("upd_first", 1'b1, 3'd2, 2'd1, 16'h0004);
    irq_in = 4'b0001;
    tick();
    irq_in = '0;
    expect_out("upd_switch", 1'b1, 3'd0, 2'd1, 16'h0005);
    do_ack();
    expect_out("upd_ack", 1'b0, 3'd0, 2'd1, 16'h0004);
    expect_out("upd_active", 1'b0, 3'd0, 2'd2, 16'h0201);
    do_done();
    tick();
    expect_out("upd_rest", 1'b1, 3'd2, 2'd1, 16'h0004);
    do_ack();
    do_done();

    // Write-clear racing a new edge, then clearing the sole request
    do_wr(2'd0, 16'h000F);
    pulse(4'b0010);
    tick();
    irq_in = 4'b0010; cfg_we = 1'b1; cfg_addr = 2'd1; cfg_wdata = 16'h0002;
    tick();
    cfg_we = 1'b0; irq_in = '0;
    expect_out("race_edge_wins", 1'b0, 3'd0, 2'd1, 16'h0002);
    do_wr(2'd1, 16'h0002);
    expect_out("wc_clear", 1'b0, 3'd0, 2'd1, 16'h0000);
    do_wr(2'd0, 16'h800F);
    pulse(4'b0010);
    tick();
    expect_out("solo_req", 1'b1, 3'd1, 2'd1, 16'h0002);
    do_wr(2'd1, 16'h0002);
    tick();
    expect_out("solo_drop", 1'b0, 3'd0, 2'd1, 16'h0000);

    // Higher-priority arrival while source 3 is in service
    pulse(4'b1000);
    tick();
    expect_out("nest_req3", 1'b1, 3'd3, 2'd1, 16'h0008);
    do_ack();
    pulse(4'b0001);
    tick();
`ifdef REFLET_IRQ_NESTING_EN
    expect_out("nest_pre", 1'b1, 3'd0, 2'd2, 16'h0108);
    do_ack();
    expect_out("nest_ack", 1'b0, 3'd0, 2'd2, 16'h0209);
    do_done();
    expect_out("nest_pop", 1'b0, 3'd0, 2'd2, 16'h0208);
    do_done();
    expect_out("nest_idle", 1'b0, 3'd0, 2'd2, 16'h0000);
`else
    expect_out("nopre_hold", 1'b0, 3'd0, 2'd2, 16'h0208);
    expect_out("nopre_pend", 1'b0, 3'd0, 2'd1, 16'h0001);
    do_done();
    expect_out("nopre_done", 1'b0, 3'd0, 2'd2, 16'h0000);
    tick();
    expect_out("nopre_req", 1'b1, 3'd0, 2'd1, 16'h0001);
    do_ack();
    do_done();
`endif

    // Asynchronous reset while in service
    pulse(4'b0100);
    tick();
    do_ack();
    #2;
    reset = 1'b1;
    expect_out("rst_async", 1'b0, 3'd0, 2'd2, 16'h0000);
    reset = 1'b0;
    tick();
    expect_out("rst_enable", 1'b0, 3'd0, 2'd0, 16'h0000);
    expect_out("rst_pending", 1'b0, 3'd0, 2'd1, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, want finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
